// File: rtl/mem_fabric_pkg.sv
// Shared types, constants and the round-robin search helper for the memory fabric.
package mem_fabric_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [31:0] ERR_RDATA_DEF = 32'hDEADBEEF;

    // Returns {found, index} of the first set bit of req at or after start, wrapping modulo n (n <= 8).
    function automatic logic [3:0] first_set_from(input logic [7:0] req,
                                                  input logic [2:0] start,
                                                  input int         n);
        logic [3:0] res;
        int         idx;
        res = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (i < n) begin
                idx = (int'(start) + i) % n;
                res = req[idx] ? {1'b1, idx[2:0]} : res;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_fabric_rr_arbiter.sv
// Combinational NM-wide round-robin: picks the first requester after last_grant.
module rr_arbiter
    import mem_fabric_pkg::*;
#(
    parameter int NM = 2,
    parameter int MW = 1
) (
    input  logic [NM-1:0] req_i,
    input  logic [MW-1:0] last_grant_i,
    output logic [MW-1:0] grant_o,
    output logic          any_o
);

    logic [7:0] req_ext_s;
    logic [2:0] start_s;
    logic [3:0] res_s;

    // Widen the request vector and search from the slot after the last winner.
    always_comb begin
        req_ext_s         = 8'd0;
        req_ext_s[NM-1:0] = req_i;
        start_s           = 3'((int'(last_grant_i) + 1) % NM);
        res_s             = first_set_from(req_ext_s, start_s, NM);
        grant_o           = MW'(res_s[2:0]);
        any_o             = res_s[3];
    end

endmodule

// File: rtl/mem_fabric.sv
// Multi-master, address-windowed memory fabric with round-robin arbitration and a
// watchdog that terminates hung or unmapped accesses with an error response.
module mem_fabric
    import mem_fabric_pkg::*;
#(
    parameter int               NM         = 2,
    parameter int               NS         = 4,
    parameter logic [NS*32-1:0] SLAVE_BASE = {NS{32'h0}},
    parameter logic [NS*32-1:0] SLAVE_MASK = {NS{32'h0}},
    parameter int               TIMEOUT    = 1024,
    parameter logic [31:0]      ERR_RDATA  = ERR_RDATA_DEF
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic [NM-1:0]                         m_valid,
    output logic [NM-1:0]                         m_ready,
    input  logic [NM*32-1:0]                      m_addr,
    input  logic [NM*32-1:0]                      m_wdata,
    input  logic [NM*4-1:0]                       m_wstrb,
    output logic [31:0]                           m_rdata,
    output logic [NS-1:0]                         s_valid,
    input  logic [NS-1:0]                         s_ready,
    output logic [31:0]                           s_addr,
    output logic [31:0]                           s_wdata,
    output logic [3:0]                            s_wstrb,
    input  logic [NS*32-1:0]                      s_rdata,
    output logic                                  err_pulse,
    output logic [31:0]                           err_addr,
    output logic [((NM > 1) ? $clog2(NM) : 1)-1:0] err_master
);

    localparam int MW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW = (NS > 1) ? $clog2(NS) : 1;

    state_e          state_q, state_d;
    logic [MW-1:0]   last_grant_q, last_grant_d;
    logic [MW-1:0]   grant_q, grant_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic            unmapped_q, unmapped_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [31:0]     err_addr_q, err_addr_d;
    logic [MW-1:0]   err_master_q, err_master_d;

    logic [MW-1:0]   arb_idx_s;
    logic            arb_any_s;
    logic [31:0]     req_addr_s;
    logic [SW-1:0]   dec_sel_s;
    logic            dec_hit_s;
    logic            hit_s;
    logic            mv_s;
    logic            norm_s;
    logic            wd_s;
    logic            err_s;

    rr_arbiter #(
        .NM(NM),
        .MW(MW)
    ) u_arb (
        .req_i       (m_valid),
        .last_grant_i(last_grant_q),
        .grant_o     (arb_idx_s),
        .any_o       (arb_any_s)
    );

    // Address decode of the arbitration winner; scanning downward lets the lowest hit win.
    always_comb begin
        req_addr_s = m_addr[int'(arb_idx_s)*32 +: 32];
        dec_sel_s  = '0;
        dec_hit_s  = 1'b0;
        hit_s      = 1'b0;
        for (int i = NS - 1; i >= 0; i--) begin
            hit_s     = (req_addr_s & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32];
            dec_sel_s = hit_s ? SW'(i) : dec_sel_s;
            dec_hit_s = hit_s | dec_hit_s;
        end
    end

    // Request routing, completion and watchdog for the granted transaction.
    always_comb begin
        mv_s    = 1'b0;
        norm_s  = 1'b0;
        wd_s    = 1'b0;
        err_s   = 1'b0;
        s_valid = '0;
        m_ready = '0;
        m_rdata = 32'h0;
        s_addr  = 32'h0;
        s_wdata = 32'h0;
        s_wstrb = 4'h0;
        if (state_q == ST_BUSY) begin
            mv_s             = m_valid[grant_q];
            s_addr           = m_addr[int'(grant_q)*32 +: 32];
            s_wdata          = m_wdata[int'(grant_q)*32 +: 32];
            s_wstrb          = m_wstrb[int'(grant_q)*4 +: 4];
            s_valid[sel_q]   = mv_s && !unmapped_q;
            norm_s           = s_valid[sel_q] && s_ready[sel_q];
            // A slave answering in the last watchdog cycle still completes normally.
            wd_s             = (TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1)) && mv_s && !norm_s;
            err_s            = (mv_s && unmapped_q) || wd_s;
            m_ready[grant_q] = norm_s || err_s;
            m_rdata          = norm_s ? s_rdata[int'(sel_q)*32 +: 32] :
                               (err_s ? ERR_RDATA : 32'h0);
        end else begin
            mv_s = 1'b0;
        end
    end

    assign err_pulse  = err_s;
    assign err_addr   = err_addr_q;
    assign err_master = err_master_q;

    // Next-state: arbitration in IDLE, completion / abort bookkeeping in BUSY.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        sel_d        = sel_q;
        unmapped_d   = unmapped_q;
        cnt_d        = cnt_q;
        err_addr_d   = err_addr_q;
        err_master_d = err_master_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 32'h0;
                if (arb_any_s) begin
                    state_d    = ST_BUSY;
                    grant_d    = arb_idx_s;
                    sel_d      = dec_sel_s;
                    unmapped_d = !dec_hit_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 32'd1;
                // A master dropping its request abandons the transaction silently.
                if (norm_s || err_s || !mv_s) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                end else begin
                    state_d = ST_BUSY;
                end
                if (err_s) begin
                    err_addr_d   = s_addr;
                    err_master_d = grant_q;
                end else begin
                    err_addr_d = err_addr_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= MW'(NM - 1);
            grant_q      <= '0;
            sel_q        <= '0;
            unmapped_q   <= 1'b0;
            cnt_q        <= 32'h0;
            err_addr_q   <= 32'h0;
            err_master_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            sel_q        <= sel_d;
            unmapped_q   <= unmapped_d;
            cnt_q        <= cnt_d;
            err_addr_q   <= err_addr_d;
            err_master_q <= err_master_d;
        end
    end

endmodule

// File: tb/tb_mem_fabric.sv
// Scoreboard bench for mem_fabric: directed master requests, a latency-programmable
// slave model, and a monitor that checks every completion against queued expectations.
module tb_mem_fabric;

    localparam int NM = 2;
    localparam int NS = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        int          m;
        logic [31:0] saddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          gap;
    } exp_t;

    logic             clk;
    logic             rstn;
    logic [NM-1:0]    m_valid;
    logic [NM-1:0]    m_ready;
    logic [NM*32-1:0] m_addr;
    logic [NM*32-1:0] m_wdata;
    logic [NM*4-1:0]  m_wstrb;
    logic [31:0]      m_rdata;
    logic [NS-1:0]    s_valid;
    logic [NS-1:0]    s_ready;
    logic [31:0]      s_addr;
    logic [31:0]      s_wdata;
    logic [3:0]       s_wstrb;
    logic [NS*32-1:0] s_rdata;
    logic             err_pulse;
    logic [31:0]      err_addr;
    logic [0:0]       err_master;

    logic [31:0] rd  [NS];
    int          lat [NS];
    int          scnt[NS];
    int          sv_seen[NS];
    int          vcyc[NM];
    logic [NM-1:0] done_seen;
    int          cyc;
    int          last_done;
    int          n_chk;
    int          n_err;
    req_t        mq0[$];
    req_t        mq1[$];
    exp_t        expq[$];
    exp_t        mon_e;

    mem_fabric #(
        .NM        (NM),
        .NS        (NS),
        .SLAVE_BASE({32'h03000000, 32'h00000000, 32'h02000000, 32'h00000000}),
        .SLAVE_MASK({32'hFF000000, 32'hFFFF0000, 32'hFF000000, 32'hFFFFFC00}),
        .TIMEOUT   (16),
        .ERR_RDATA (32'hDEADBEEF)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_rdata   (m_rdata),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_rdata   (s_rdata),
        .err_pulse (err_pulse),
        .err_addr  (err_addr),
        .err_master(err_master)
    );

    assign s_rdata = {rd[3], rd[2], rd[1], rd[0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input int m, input logic [31:0] saddr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input logic [31:0] rdata,
                            input logic err, input int l, input int gap);
        exp_t e;
        e.m = m; e.saddr = saddr; e.wdata = wdata; e.wstrb = wstrb;
        e.rdata = rdata; e.err = err; e.lat = l; e.gap = gap;
        expq.push_back(e);
    endtask

    task automatic put_req(input int m, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws);
        req_t r;
        r.addr = a; r.wdata = wd; r.wstrb = ws;
        if (m == 0) mq0.push_back(r);
        else        mq1.push_back(r);
    endtask

    task automatic present(input int m, input req_t r);
        m_addr[m*32 +: 32]  = r.addr;
        m_wdata[m*32 +: 32] = r.wdata;
        m_wstrb[m*4 +: 4]   = r.wstrb;
        m_valid[m]          = 1'b1;
        vcyc[m]             = 0;
    endtask

    task automatic wait_drain(input int budget, input string nm);
        int k;
        k = 0;
        while (expq.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(nm, 32'(expq.size()), 32'h0);
        expq.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_seen();
        for (int i = 0; i < NS; i++) sv_seen[i] = 0;
    endtask

    // Master drivers: retire on completion, then present the next queued request.
    always @(posedge clk) begin
        #1;
        if (m_valid[0] && done_seen[0]) begin
            void'(mq0.pop_front());
            m_valid[0] = 1'b0;
        end
        if (!m_valid[0] && mq0.size() > 0) present(0, mq0[0]);
        if (m_valid[1] && done_seen[1]) begin
            void'(mq1.pop_front());
            m_valid[1] = 1'b0;
        end
        if (!m_valid[1] && mq1.size() > 0) present(1, mq1[0]);
        done_seen = '0;
    end

    // Slave model: ready once s_valid has been high for lat[i] earlier cycles.
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < NS; i++) begin
            if (s_valid[i]) begin
                s_ready[i] = (scnt[i] >= lat[i]);
                scnt[i]++;
            end else begin
                s_ready[i] = 1'b0;
                scnt[i]    = 0;
            end
        end
    end

    // Monitor: pop one expectation per completion and compare.
    always @(negedge clk) begin
        if (rstn) begin
            for (int i = 0; i < NS; i++) if (s_valid[i]) sv_seen[i]++;
            for (int m = 0; m < NM; m++) if (m_valid[m]) vcyc[m]++;
            if (err_pulse && (m_ready == '0)) check("err_pulse_alone", 32'(err_pulse), 32'h0);
            if (m_ready != '0) begin
                done_seen = m_ready;
                if (expq.size() == 0) begin
                    check("unexpected_ready", 32'(m_ready), 32'h0);
                end else begin
                    mon_e = expq.pop_front();
                    check("ready_vec", 32'(m_ready), 32'h1 << mon_e.m);
                    check("m_rdata", m_rdata, mon_e.rdata);
                    check("s_addr", s_addr, mon_e.saddr);
                    check("s_wdata", s_wdata, mon_e.wdata);
                    check("s_wstrb", 32'(s_wstrb), 32'(mon_e.wstrb));
                    check("err_pulse", 32'(err_pulse), 32'(mon_e.err));
                    if (mon_e.lat != 0) check("latency", 32'(vcyc[mon_e.m]), 32'(mon_e.lat));
                    if (mon_e.gap != 0) check("ready_gap", 32'(cyc - last_done), 32'(mon_e.gap));
                end
                last_done = cyc;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        n_chk = 0; n_err = 0; cyc = 0; last_done = 0;
        m_valid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        s_ready = '0; done_seen = '0;
        for (int i = 0; i < NS; i++) begin
            rd[i] = 32'h0; lat[i] = 0; scnt[i] = 0; sv_seen[i] = 0;
        end
        for (int m = 0; m < NM; m++) vcyc[m] = 0;
        rd[0] = 32'hA0A0A0A0; rd[1] = 32'h12345678; rd[2] = 32'h22222222; rd[3] = 32'h33330003;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_ready", 32'(m_ready), 32'h0);
        check("rst_s_valid", 32'(s_valid), 32'h0);
        check("rst_err_pulse", 32'(err_pulse), 32'h0);
        check("rst_err_addr", err_addr, 32'h0);
        check("rst_err_master", 32'(err_master), 32'h0);
        rstn = 1'b1;

        // Single read to slave1, three wait states.
        lat[1] = 3;
        push_exp(0, 32'h02000010, 32'h0, 4'h0, 32'h12345678, 1'b0, 5, 0);
        put_req(0, 32'h02000010, 32'h0, 4'h0);
        wait_drain(40, "drain_single");

        // Unmapped write from master 1.
        clear_seen();
        push_exp(1, 32'hF0000000, 32'h55AA55AA, 4'hF, 32'hDEADBEEF, 1'b1, 2, 0);
        put_req(1, 32'hF0000000, 32'h55AA55AA, 4'hF);
        wait_drain(40, "drain_unmapped");
        check("unmapped_err_addr", err_addr, 32'hF0000000);
        check("unmapped_err_master", 32'(err_master), 32'h1);
        check("unmapped_no_s_valid", 32'(sv_seen[0] + sv_seen[1] + sv_seen[2] + sv_seen[3]), 32'h0);

        // Both masters contend with zero-wait slaves: strict alternation.
        lat[1] = 0; lat[3] = 0;
        for (int k = 0; k < 3; k++) begin
            push_exp(0, 32'h02000100 + 32'(4*k), 32'h0, 4'h0, 32'h12345678, 1'b0,
                     (k == 0) ? 2 : 0, (k == 0) ? 0 : 2);
            push_exp(1, 32'h03000100 + 32'(4*k), 32'h00001000 + 32'(k), 4'h3, 32'h33330003,
                     1'b0, 0, 2);
            put_req(0, 32'h02000100 + 32'(4*k), 32'h0, 4'h0);
            put_req(1, 32'h03000100 + 32'(4*k), 32'h00001000 + 32'(k), 4'h3);
        end
        wait_drain(60, "drain_arb");

        // Watchdog fires in BUSY cycle 16 on a silent slave.
        lat[3] = 255;
        push_exp(0, 32'h03000040, 32'h0, 4'h0, 32'hDEADBEEF, 1'b1, 17, 0);
        put_req(0, 32'h03000040, 32'h0, 4'h0);
        wait_drain(60, "drain_timeout");
        check("timeout_err_addr", err_addr, 32'h03000040);
        check("timeout_err_master", 32'(err_master), 32'h0);

        // Slave answering in BUSY cycle 16 beats the watchdog.
        lat[3] = 15;
        push_exp(0, 32'h03000044, 32'h0, 4'h0, 32'h33330003, 1'b0, 17, 0);
        put_req(0, 32'h03000044, 32'h0, 4'h0);
        wait_drain(60, "drain_late_ready");
        check("late_ready_err_addr_kept", err_addr, 32'h03000040);

        // Overlapping windows: slave0 wins over slave2.
        clear_seen();
        lat[0] = 1; lat[2] = 0;
        push_exp(1, 32'h00000100, 32'h0, 4'h0, 32'hA0A0A0A0, 1'b0, 3, 0);
        put_req(1, 32'h00000100, 32'h0, 4'h0);
        wait_drain(40, "drain_overlap");
        check("overlap_s2_quiet", 32'(sv_seen[2]), 32'h0);
        check("overlap_s0_cycles", 32'(sv_seen[0]), 32'h2);

        // Make master 0 the last winner, then reset during a stalled access.
        lat[1] = 0;
        push_exp(0, 32'h02000020, 32'h0, 4'h0, 32'h12345678, 1'b0, 2, 0);
        put_req(0, 32'h02000020, 32'h0, 4'h0);
        wait_drain(40, "drain_pre_reset");
        lat[1] = 255;
        put_req(0, 32'h02000030, 32'h0, 4'h0);
        repeat (6) @(negedge clk);
        check("stall_s_valid", 32'(s_valid), 32'h2);
        rstn = 1'b0;
        lat[1] = 0;
        push_exp(0, 32'h02000030, 32'h0, 4'h0, 32'h12345678, 1'b0, 0, 0);
        push_exp(1, 32'h03000010, 32'h0, 4'h0, 32'h33330003, 1'b0, 0, 0);
        put_req(1, 32'h03000010, 32'h0, 4'h0);
        @(negedge clk);
        check("midrst_s_valid", 32'(s_valid), 32'h0);
        check("midrst_m_ready", 32'(m_ready), 32'h0);
        rstn = 1'b1;
        wait_drain(40, "drain_post_reset");

        check("m0_queue_empty", 32'(mq0.size()), 32'h0);
        check("m1_queue_empty", 32'(mq1.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
